// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce FSM,
// one-clock step pulse on press and optional auto-repeat while held.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pulse,
    output logic rpt,
    output logic pressed
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    logic [1:0]       sync_reg;
    logic             btn_s;
    state_t           state_reg;
    logic [CNT_W-1:0] dcnt_reg;
    logic [CNT_W-1:0] rcnt_reg;
    logic             phase_reg;
    logic             pulse_reg;
    logic             rpt_reg;
    logic             pressed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_in};
        end
    end

    assign btn_s = sync_reg[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            dcnt_reg    <= '0;
            rcnt_reg    <= '0;
            phase_reg   <= 1'b0;
            pulse_reg   <= 1'b0;
            rpt_reg     <= 1'b0;
            pressed_reg <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            rpt_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg <= DB_PRESS;
                        dcnt_reg  <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_s) begin
                        state_reg <= IDLE;
                    end else if (dcnt_reg == DB_LAST) begin
                        state_reg   <= HELD;
                        pulse_reg   <= 1'b1;
                        pressed_reg <= 1'b1;
                        rcnt_reg    <= '0;
                        phase_reg   <= 1'b0;
                    end else begin
                        dcnt_reg <= dcnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    // Leaving for DB_REL keeps rcnt/phase so a rejected glitch resumes the cadence
                    if (!btn_s) begin
                        state_reg <= DB_REL;
                        dcnt_reg  <= '0;
                    end else if (!repeat_en) begin
                        rcnt_reg  <= '0;
                        phase_reg <= 1'b0;
                    end else if (rcnt_reg == (phase_reg ? RP_LAST : RD_LAST)) begin
                        pulse_reg <= 1'b1;
                        rpt_reg   <= 1'b1;
                        rcnt_reg  <= '0;
                        phase_reg <= 1'b1;
                    end else begin
                        rcnt_reg <= rcnt_reg + 1'b1;
                    end
                end
                DB_REL: begin
                    if (btn_s) begin
                        state_reg <= HELD;
                    end else if (dcnt_reg == DB_LAST) begin
                        state_reg   <= IDLE;
                        pressed_reg <= 1'b0;
                    end else begin
                        dcnt_reg <= dcnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pulse   = pulse_reg;
    assign rpt     = rpt_reg;
    assign pressed = pressed_reg;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen: expected pulse cycles are queued as
// stimulus is applied and matched against every pulse the DUT emits.
module tb_btn_pulse_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic repeat_en = 1'b0;
    logic pulse;
    logic rpt;
    logic pressed;

    int cyc = 0;
    int check_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        int   cyc;
        logic rpt;
    } exp_t;

    exp_t exp_q[$];

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .pulse    (pulse),
        .rpt      (rpt),
        .pressed  (pressed)
    );

    always #5 clk = ~clk;

    // Edge counter: at the negedge after rising edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic r);
        exp_t e;
        e.cyc = c;
        e.rpt = r;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drop the button and confirm pressed falls exactly 7 edges later.
    task automatic release_and_check(input string tag);
        int t;
        btn_in = 1'b0;
        t = cyc;
        wait_to(t + 6);
        check_val({tag, "_pressed_before_rel"}, pressed, 1);
        wait_to(t + 7);
        check_val({tag, "_pressed_after_rel"}, pressed, 0);
        tick(4);
        check_val({tag, "_pending_pulses"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (pulse === 1'b1) begin
            $display("pulse cyc=%0d rpt=%0b pressed=%0b", cyc, rpt, pressed);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", pulse, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("pulse_cyc", cyc, e.cyc);
                check_val("pulse_rpt", rpt, e.rpt);
            end
        end else if (rpt !== 1'b0) begin
            check_val("rpt_without_pulse", rpt, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p;

        // Reset held with the button down: everything stays low.
        btn_in = 1'b1;
        repeat_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rst_pulse", pulse, 0);
            check_val("rst_rpt", rpt, 0);
            check_val("rst_pressed", pressed, 0);
        end
        rst = 1'b0;
        t0 = cyc;
        push_exp(t0 + 7, 1'b0);
        wait_to(t0 + 6);
        check_val("rst_rel_pressed_pre", pressed, 0);
        wait_to(t0 + 7);
        check_val("rst_rel_pressed", pressed, 1);
        wait_to(t0 + 15);
        release_and_check("rst_rel");

        // Bounce: 3 clocks high is too short to be accepted.
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        tick(10);
        check_val("bounce_pressed", pressed, 0);
        check_val("bounce_pending", exp_q.size(), 0);

        // Clean press, no repeat.
        repeat_en = 1'b0;
        btn_in = 1'b1;
        t0 = cyc;
        push_exp(t0 + 7, 1'b0);
        wait_to(t0 + 7);
        check_val("clean_pressed", pressed, 1);
        wait_to(t0 + 25);
        release_and_check("clean");

        // Auto-repeat cadence.
        repeat_en = 1'b1;
        btn_in = 1'b1;
        t0 = cyc;
        p = t0 + 7;
        push_exp(p, 1'b0);
        for (int k = 0; k < 7; k++) push_exp(p + 10 + 3 * k, 1'b1);
        wait_to(p + 28);
        release_and_check("repeat");

        // repeat_en drop mid-hold suppresses the due repeat and restarts the delay.
        btn_in = 1'b1;
        t0 = cyc;
        p = t0 + 7;
        push_exp(p, 1'b0);
        push_exp(p + 10, 1'b1);
        push_exp(p + 25, 1'b1);
        push_exp(p + 28, 1'b1);
        wait_to(p + 12);
        repeat_en = 1'b0;
        wait_to(p + 15);
        repeat_en = 1'b1;
        wait_to(p + 28);
        release_and_check("en_drop");

        // Release glitch of 2 clocks: pressed holds, cadence slips by 3 frozen clocks.
        btn_in = 1'b1;
        t0 = cyc;
        p = t0 + 7;
        push_exp(p, 1'b0);
        push_exp(p + 10, 1'b1);
        push_exp(p + 13, 1'b1);
        push_exp(p + 16, 1'b1);
        push_exp(p + 22, 1'b1);
        push_exp(p + 25, 1'b1);
        push_exp(p + 28, 1'b1);
        wait_to(p + 14);
        btn_in = 1'b0;
        wait_to(p + 16);
        btn_in = 1'b1;
        for (int k = 17; k <= 20; k++) begin
            wait_to(p + k);
            check_val("glitch_pressed", pressed, 1);
        end
        wait_to(p + 28);
        release_and_check("glitch");

        // Reset while repeating: outputs drop at once, then a fresh press runs.
        btn_in = 1'b1;
        t0 = cyc;
        p = t0 + 7;
        push_exp(p, 1'b0);
        push_exp(p + 10, 1'b1);
        push_exp(p + 13, 1'b1);
        wait_to(p + 13);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_pulse", pulse, 0);
        check_val("midrst_rpt", rpt, 0);
        check_val("midrst_pressed", pressed, 0);
        check_val("midrst_pending", exp_q.size(), 0);
        tick(3);
        rst = 1'b0;
        t0 = cyc;
        push_exp(t0 + 7, 1'b0);
        push_exp(t0 + 17, 1'b1);
        wait_to(t0 + 6);
        check_val("midrst_rel_pressed_pre", pressed, 0);
        wait_to(t0 + 7);
        check_val("midrst_rel_pressed", pressed, 1);
        wait_to(t0 + 17);
        release_and_check("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Conditions a raw, bouncing push-button into a clean one-clock `pulse` plus a debounced `pressed` level.
- Sits between the board pin and any button-stepped state sequencer, e.g. mode/state-select FSMs in the clock design. It supplies the step strobe those blocks advance on.
- Optional auto-repeat issues further pulses while the button is held, for fast-setting time digits.

Parameters:
- DEBOUNCE_CYCLES, 4, stable clocks required to accept a press or release; must be >= 2.
- REPEAT_DELAY, 10, clocks from the initial pulse to the first repeat pulse; must be >= 2.
- REPEAT_PERIOD, 3, clocks between successive repeat pulses; must be >= 2.
- CNT_W, 16, width of the debounce and repeat counters; must hold max(all three counts) - 1.

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw button, asynchronous to clk, active-high.
- repeat_en  input  1  enables auto-repeat while held; synchronous to clk.
- pulse  output  1  one-clock strobe: initial press and every repeat.
- rpt  output  1  one-clock strobe, high only on repeat pulses (a subset of pulse).
- pressed  output  1  debounced button level.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high, all flops clear immediately:
  - sync stages = 0, state = IDLE, counters = 0;
  - pulse = 0, rpt = 0, pressed = 0.
- Synchroniser: two-flop chain on btn_in. The FSM sees only btn_s, the second stage.
- All outputs are registered. pulse and rpt are never high two consecutive cycles.
- States: IDLE, DB_PRESS, HELD, DB_REL. Counters: dcnt (debounce), rcnt (repeat), phase bit (0 = waiting delay, 1 = periodic).
- IDLE (pressed = 0):
  - btn_s = 1 -> DB_PRESS, dcnt = 0.
- DB_PRESS (pressed = 0):
  - btn_s = 0 -> IDLE; bounce rejected, no pulse.
  - Else if dcnt == DEBOUNCE_CYCLES-1 -> HELD: pulse = 1 for one cycle, pressed = 1, rcnt = 0, phase = 0.
  - Else dcnt += 1.
- Press latency: counting the first clk edge that samples btn_in high as edge 1, pulse is registered high at edge DEBOUNCE_CYCLES+3 (edge 7 with defaults).
- HELD (pressed = 1):
  - btn_s = 0 -> DB_REL, dcnt = 0; rcnt and phase frozen.
  - Else if repeat_en = 0: rcnt = 0, phase = 0, no pulses.
  - Else rcnt += 1. On reaching the limit (REPEAT_DELAY-1 when phase = 0, REPEAT_PERIOD-1 when phase = 1): pulse = 1, rpt = 1, rcnt = 0, phase = 1.
  - Result: first repeat REPEAT_DELAY clocks after the initial pulse, then every REPEAT_PERIOD clocks.
- DB_REL (pressed = 1):
  - btn_s = 1 -> HELD; release glitch rejected, no pulse, repeat resumes from its frozen rcnt/phase.
  - Else if dcnt == DEBOUNCE_CYCLES-1 -> IDLE, pressed = 0.
  - Else dcnt += 1.
- Release latency: pressed falls at edge DEBOUNCE_CYCLES+3 after btn_in falls, counted the same way as press latency.
- No pulse is ever generated on release.
- repeat_en falling mid-hold: takes effect the next clock. No rpt is issued on that clock; counters clear.
- Reset mid-operation: outputs drop asynchronously.
  - After rst deasserts with btn_in still high, a full debounce runs again.
  - Exactly one new pulse is produced, at the same latency as a fresh press.
- Counters never wrap: each is cleared at its terminal count or on state entry.

Test Plan:
- Reset: rst = 1 with btn_in = 1 for 5 clks -> pulse = rpt = pressed = 0. Release rst with btn held -> single pulse at edge 7, pressed = 1 from the same edge.
- Bounce: btn_in high for 3 clks then low (DEBOUNCE_CYCLES = 4) -> no pulse, pressed stays 0, FSM back in IDLE.
- Clean press, repeat_en = 0: btn_in high 25 clks -> exactly one pulse, rpt never high. pressed falls 7 edges after btn_in falls.
- Auto-repeat, repeat_en = 1: hold 30 clks past the initial pulse -> pulse with rpt = 1 at +10, +13, +16, +19, +22, +25, +28 clks.
- Release glitch: during HELD, btn_in low for 2 clks -> pressed stays 1, no extra pulse. With repeat_en = 1, the repeat cadence resumes delayed by the frozen clocks.
- Reset mid-HELD while repeating -> outputs 0 immediately. After rst release with btn high -> one pulse at edge 7 and rpt first asserting 10 clks later.
